// File: rtl/clk_div_pkg.sv
// Shared constants, types and helpers for the multi-channel clock divider.
// Optional duty-cycle control is enabled by defining CLKDIV_DUTY_EN.
package clk_div_pkg;

  localparam int DEF_CNT_W = 27;
  localparam int DEF_DIV   = 50_000_000;
  localparam int MAX_CH    = 8;

  // Wide enough to index the largest supported channel count.
  typedef logic [$clog2(MAX_CH)-1:0] ch_idx_t;

  // ceil(v/2) without overflow: (v >> 1) + lsb.
  function automatic logic [63:0] half_ceil(input logic [63:0] v);
    return (v >> 1) + {63'd0, v[0]};
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, active/shadow divisor, tick and clk_out flops.
// With CLKDIV_DUTY_EN defined, a shadowed duty register sets the high time.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int DEFAULT_DIV = DEF_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             load,
  input  logic [CNT_W-1:0] div_val,
`ifdef CLKDIV_DUTY_EN
  input  logic [CNT_W-1:0] duty_val,
`endif
  output logic             tick,
  output logic             clk_out,
  output logic             pending
);

  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0] c;
  logic [CNT_W-1:0] d;
  logic [CNT_W-1:0] s;
  logic [CNT_W-1:0] h;
  logic             halted;
  logic             wrap;

`ifdef CLKDIV_DUTY_EN
  localparam logic [CNT_W-1:0] RST_DUTY = CNT_W'(half_ceil(64'(DEFAULT_DIV)));
  logic [CNT_W-1:0] duty_d;
  logic [CNT_W-1:0] duty_s;
  assign h = duty_d;
`else
  assign h = CNT_W'(half_ceil(64'(d)));
`endif

  assign halted = (d == '0);
  assign wrap   = en && !halted && (c == d - ONE);

  // NOTE: state flops use non-blocking assignments so every register samples
  // pre-edge values; later assignments in this block override earlier ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      c       <= '0;
      d       <= RST_DIV;
      s       <= RST_DIV;
      pending <= 1'b0;
      tick    <= 1'b0;
      clk_out <= 1'b0;
`ifdef CLKDIV_DUTY_EN
      duty_d  <= RST_DUTY;
      duty_s  <= RST_DUTY;
`endif
    end else if (sync) begin
      // A load in the sync cycle bypasses the shadow and becomes active now.
      c       <= '0;
      d       <= load ? div_val : s;
      s       <= load ? div_val : s;
      pending <= 1'b0;
      tick    <= 1'b0;
      clk_out <= 1'b0;
`ifdef CLKDIV_DUTY_EN
      duty_d  <= load ? duty_val : duty_s;
      duty_s  <= load ? duty_val : duty_s;
`endif
    end else begin
      if (load) begin
        s       <= div_val;
        pending <= 1'b1;
`ifdef CLKDIV_DUTY_EN
        duty_s  <= duty_val;
`endif
      end

      if (halted) begin
        // No period is in progress, so a load takes effect immediately.
        c       <= '0;
        tick    <= 1'b0;
        clk_out <= 1'b0;
        if (load) begin
          d       <= div_val;
          pending <= 1'b0;
`ifdef CLKDIV_DUTY_EN
          duty_d  <= duty_val;
`endif
        end
      end else if (en) begin
        c       <= wrap ? '0 : c + ONE;
        tick    <= wrap;
        clk_out <= (c < h);
        if (wrap) begin
          d <= s;
`ifdef CLKDIV_DUTY_EN
          duty_d <= duty_s;
`endif
          // A load landing on the wrap edge stays pending for the next period.
          if (!load) pending <= 1'b0;
        end
      end else begin
        tick <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/multi_clock_divider.sv
// NUM_CH independent runtime-programmable clock dividers sharing en/sync/rst.
// Define CLKDIV_DUTY_EN to add the duty_val input and per-channel duty control.
module multi_clock_divider
  import clk_div_pkg::*;
#(
  parameter int  NUM_CH      = 2,
  parameter int  CNT_W       = DEF_CNT_W,
  parameter int  DEFAULT_DIV = DEF_DIV,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sync,
  input  logic              div_load,
  input  logic [CH_W-1:0]   div_ch,
  input  logic [CNT_W-1:0]  div_val,
`ifdef CLKDIV_DUTY_EN
  input  logic [CNT_W-1:0]  duty_val,
`endif
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] pending
);

  logic [NUM_CH-1:0] load;

  // Out-of-range channel numbers match no channel and are dropped.
  always_comb begin
    load = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      load[i] = div_load && (ch_idx_t'(div_ch) == ch_idx_t'(i));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .sync     (sync),
      .load     (load[g]),
      .div_val  (div_val),
`ifdef CLKDIV_DUTY_EN
      .duty_val (duty_val),
`endif
      .tick     (tick[g]),
      .clk_out  (clk_out[g]),
      .pending  (pending[g])
    );
  end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Directed self-checking bench for multi_clock_divider (3 channels, 8-bit, default 7).
// Define CLKDIV_DUTY_EN to also exercise the duty-cycle variant.
module tb_multi_clock_divider;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 8;
  localparam int DEF_D  = 7;
  localparam int CH_W   = 2;

  logic              clk;
  logic              rst;
  logic              en;
  logic              sync;
  logic              div_load;
  logic [CH_W-1:0]   div_ch;
  logic [CNT_W-1:0]  div_val;
`ifdef CLKDIV_DUTY_EN
  logic [CNT_W-1:0]  duty_val;
`endif
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] pending;

  int n_checks = 0;
  int n_errors = 0;

  multi_clock_divider #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEF_D)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sync     (sync),
    .div_load (div_load),
    .div_ch   (div_ch),
    .div_val  (div_val),
`ifdef CLKDIV_DUTY_EN
    .duty_val (duty_val),
`endif
    .tick     (tick),
    .clk_out  (clk_out),
    .pending  (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic capture(input int ch, input int n,
                         output logic [31:0] tk, output logic [31:0] co,
                         output logic [31:0] pd);
    tk = '0;
    co = '0;
    pd = '0;
    for (int k = 0; k < n; k++) begin
      cyc();
      tk[k] = tick[ch];
      co[k] = clk_out[ch];
      pd[k] = pending[ch];
    end
  endtask

  task automatic load_div(input int ch, input int val, input logic with_sync);
    div_load = 1'b1;
    div_ch   = CH_W'(ch);
    div_val  = CNT_W'(val);
    sync     = with_sync;
`ifdef CLKDIV_DUTY_EN
    duty_val = CNT_W'((val + 1) / 2);
`endif
    cyc();
    div_load = 1'b0;
    sync     = 1'b0;
  endtask

  logic [31:0] tk, co, pd;
  int first_tick, highs;
  bit seen;

  initial begin
    rst = 1'b1; en = 1'b0; sync = 1'b0; div_load = 1'b0;
    div_ch = '0; div_val = '0;
`ifdef CLKDIV_DUTY_EN
    duty_val = '0;
`endif
    cyc(); cyc();
    check("rst_tick",    32'(tick),    32'h0);
    check("rst_clk_out", 32'(clk_out), 32'h0);
    check("rst_pending", 32'(pending), 32'h0);

    // Default divisor 7 (H=4) from the first enabled cycle after reset.
    rst = 1'b0; en = 1'b1;
    capture(0, 16, tk, co, pd);
    check("def_tick", tk, 32'h2040);
    check("def_clk",  co, 32'hC78F);

    // ch0 = 4 via shadow, then sync applies it.
    load_div(0, 4, 1'b0);
    check("load_pending", 32'(pending), 32'h1);
    sync = 1'b1; cyc(); sync = 1'b0;
    check("sync_pending", 32'(pending), 32'h0);
    check("sync_tick",    32'(tick),    32'h0);
    check("sync_clk_out", 32'(clk_out), 32'h0);
    capture(0, 12, tk, co, pd);
    check("d4_tick", tk, 32'h888);
    check("d4_clk",  co, 32'h333);

    // ch1 = 5 loaded together with sync goes straight to the active divisor.
    load_div(1, 5, 1'b1);
    check("sync_load_pending", 32'(pending), 32'h0);
    capture(1, 10, tk, co, pd);
    check("d5_tick", tk, 32'h210);
    check("d5_clk",  co, 32'hE7);

    // ch0 = 6, then load 3 while c=2: current period finishes with 6.
    load_div(0, 6, 1'b1);
    cyc(); cyc();
    load_div(0, 3, 1'b0);
    check("mid_pending", 32'(pending[0]), 32'h1);
    check("mid_clk",     32'(clk_out[0]), 32'h1);
    capture(0, 9, tk, co, pd);
    check("switch_tick",    tk, 32'h124);
    check("switch_clk",     co, 32'hD8);
    check("switch_pending", pd, 32'h3);

    // Freeze mid-period for 7 cycles, then resume where it stopped.
    cyc();
    en = 1'b0;
    capture(0, 7, tk, co, pd);
    check("frozen_tick", tk, 32'h00);
    check("frozen_clk",  co, 32'h7F);
    en = 1'b1;
    capture(0, 6, tk, co, pd);
    check("resume_tick", tk, 32'h12);
    check("resume_clk",  co, 32'h2D);

    // Halt ch1 with divisor 0 after its current period completes.
    load_div(1, 0, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      if (pending[1] == 1'b0) seen = 1'b1;
      else cyc();
    end
    check("halt_pending_clear", 32'(seen), 32'h1);
    capture(1, 8, tk, co, pd);
    check("halt_tick", tk, 32'h00);
    check("halt_clk",  co, 32'h00);

    // Restart the halted channel with divisor 2.
    load_div(1, 2, 1'b0);
    capture(1, 6, tk, co, pd);
    check("restart_tick", tk, 32'h2A);
    check("restart_clk",  co, 32'h15);

    // Out-of-range channel index is ignored.
    load_div(3, 1, 1'b0);
    check("bad_ch_pending", 32'(pending), 32'h0);

    // Maximum divisor 255 on ch2: first tick after 255 cycles, 128 high.
    load_div(2, 255, 1'b1);
    first_tick = 0;
    highs = 0;
    for (int k = 1; k <= 255; k++) begin
      cyc();
      if (tick[2] && first_tick == 0) first_tick = k;
      if (clk_out[2]) highs++;
    end
    check("max_first_tick", 32'(first_tick), 32'd255);
    check("max_high",       32'(highs),      32'd128);

    // Divisor 1: tick every cycle, clk_out constantly high.
    load_div(0, 1, 1'b1);
    capture(0, 5, tk, co, pd);
    check("d1_tick", tk, 32'h1F);
    check("d1_clk",  co, 32'h1F);

    // Reset while a load is pending discards it and restores the default.
    load_div(0, 9, 1'b0);
    check("pre_rst_pending", 32'(pending[0]), 32'h1);
    rst = 1'b1; cyc();
    check("mid_rst_tick",    32'(tick),    32'h0);
    check("mid_rst_clk_out", 32'(clk_out), 32'h0);
    check("mid_rst_pending", 32'(pending), 32'h0);
    rst = 1'b0;
    capture(0, 16, tk, co, pd);
    check("post_rst_tick", tk, 32'h2040);
    check("post_rst_clk",  co, 32'hC78F);

`ifdef CLKDIV_DUTY_EN
    // d=8 with duty 2.
    div_load = 1'b1; div_ch = 2'd0; div_val = 8'd8; duty_val = 8'd2; sync = 1'b1;
    cyc();
    div_load = 1'b0; sync = 1'b0;
    capture(0, 8, tk, co, pd);
    check("duty_tick", tk, 32'h80);
    check("duty_clk",  co, 32'h03);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
